// File: rtl/ifetch_resp.sv
// Instruction-fetch responder: single-outstanding memory read feeding a small
// output FIFO, with redirect flush that drops queued and in-flight fetches.
`timescale 1ns/1ps
module ifetch_resp #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    input  logic [AW-1:0] req_addr,
    output logic          req_ready,
    input  logic          flush,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          instr_valid,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_addr,
    output logic          instr_fault,
    input  logic          instr_ready,
    output logic          busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t        state_q, state_d;
    logic          mem_rd_q, mem_rd_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;

    logic [DW-1:0] data_q [DEPTH];
    logic [AW-1:0] addr_q [DEPTH];
    logic [DEPTH-1:0] fault_q;
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;

    logic          accept, aligned, push, pop;
    logic [DW-1:0] push_data;
    logic [AW-1:0] push_addr;
    logic          push_fault;

    assign req_ready   = (state_q == IDLE) && (count_q < CW'(DEPTH)) && !flush;
    assign accept      = req_valid && req_ready;
    assign aligned     = (req_addr[1:0] == 2'b00);
    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && instr_ready && !flush;

    always_comb begin
        state_d    = state_q;
        mem_rd_d   = mem_rd_q;
        mem_addr_d = mem_addr_q;
        push       = 1'b0;
        push_data  = '0;
        push_addr  = req_addr;
        push_fault = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (aligned) begin
                        state_d    = WAIT;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = {req_addr[AW-1:2], 2'b00};
                    end else begin
                        push       = 1'b1;
                        push_fault = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_rd_d  = 1'b0;
                    push      = !flush;
                    push_data = mem_rdata;
                    push_addr = mem_addr_q;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // the memory read cannot be aborted; swallow its response
                if (mem_ack) begin
                    state_d  = IDLE;
                    mem_rd_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                mem_rd_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            data_q[wr_ptr_q]  <= push_data;
            addr_q[wr_ptr_q]  <= push_addr;
            fault_q[wr_ptr_q] <= push_fault;
        end
    end

    // head is gated so the outputs read as zero whenever the FIFO is empty
    assign instr       = instr_valid ? data_q[rd_ptr_q]  : '0;
    assign instr_addr  = instr_valid ? addr_q[rd_ptr_q]  : '0;
    assign instr_fault = instr_valid ? fault_q[rd_ptr_q] : 1'b0;

    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign busy     = (state_q != IDLE) || instr_valid;
endmodule

// File: tb/tb_ifetch_resp.sv
// Bench for ifetch_resp: table-driven single fetches, scoreboard on the decode
// side, and hand-written stall, flush and reset sequences.
`timescale 1ns/1ps
module tb_ifetch_resp;
    localparam int AW = 32, DW = 32, DEPTH = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          req_valid = 1'b0, flush = 1'b0, instr_ready = 1'b0;
    logic          stray_ack = 1'b0, mem_ack_m = 1'b0, mem_ack;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          req_ready, mem_rd, instr_valid, instr_fault, busy;
    logic [AW-1:0] mem_addr, instr_addr;
    logic [DW-1:0] instr;

    always #5 clk = ~clk;
    assign mem_ack = mem_ack_m | stray_ack;

    ifetch_resp #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .flush(flush), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_addr(instr_addr), .instr_fault(instr_fault),
        .instr_ready(instr_ready), .busy(busy)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] instr;
        logic          fault;
    } exp_t;
    exp_t exp_q[$];

    int tests = 0, fails = 0, n_pops = 0;

    function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
        return a ^ 32'hE3A0_0101;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] info);
        tests++;
        fails++;
        $display("FAIL %s: condition not met (context 0x%08h)", name, info);
    endtask

    // memory model: acks ack_delay cycles after mem_rd is first seen
    int ack_delay = 0, wait_cnt = 0;
    always @(posedge clk) begin
        #1;
        mem_ack_m = 1'b0;
        if (rst_n && mem_rd) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack_m = 1'b1;
                mem_rdata = memfn(mem_addr);
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // scoreboard: expectations pushed on accept, popped on decode handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                exp_q.delete();
            end else begin
                if (instr_valid && instr_ready) begin
                    n_pops++;
                    if (exp_q.size() == 0) begin
                        fail_now("sb_unexpected_pop", instr_addr);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check32("sb_addr", instr_addr, e.addr);
                        check32("sb_instr", instr, e.instr);
                        check1("sb_fault", instr_fault, e.fault);
                    end
                end
                if (req_valid && req_ready) begin
                    if (req_addr[1:0] == 2'b00)
                        exp_q.push_back(exp_t'{req_addr, memfn(req_addr), 1'b0});
                    else
                        exp_q.push_back(exp_t'{req_addr, '0, 1'b1});
                end
            end
        end
    end

    task automatic present(input logic [AW-1:0] a);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = a;
    endtask

    task automatic wait_accept(input int limit, output bit ok, output bit saw_ack);
        ok = 1'b0;
        saw_ack = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (mem_ack) saw_ack = 1'b1;
            if (req_ready) ok = 1'b1;
        end
        if (!ok) fail_now("accept_timeout", req_addr);
    endtask

    task automatic wait_valid(input int limit, output bit ok, output int lat, output bit saw_rd);
        ok = 1'b0;
        lat = 1;
        saw_rd = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (mem_rd) saw_rd = 1'b1;
            if (instr_valid) ok = 1'b1;
            else lat++;
        end
        if (!ok) fail_now("valid_timeout", req_addr);
    endtask

    task automatic pop_one();
        @(posedge clk); #1;
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
    endtask

    task automatic fetch_one(input logic [AW-1:0] a, input int d, input logic [DW-1:0] ei,
                             input logic ef, input int elat, input logic emrd);
        bit ok, sa, srd;
        int lat;
        ack_delay = d;
        present(a);
        wait_accept(20, ok, sa);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!ok) return;
        wait_valid(30, ok, lat, srd);
        if (!ok) return;
        check32("fetch_latency", 32'(lat), 32'(elat));
        check32("fetch_instr", instr, ei);
        check32("fetch_addr", instr_addr, a);
        check1("fetch_fault", instr_fault, ef);
        check1("fetch_mem_rd_seen", srd, emrd);
        pop_one();
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        int            delay;
        logic [DW-1:0] instr;
        logic          fault;
        int            lat;
        logic          mrd;
    } vec_t;
    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, sa, anyready;
        int lat, pops0;
        logic [AW-1:0] bb[5];
        bb[0] = 32'h0; bb[1] = 32'h4; bb[2] = 32'h8; bb[3] = 32'hC; bb[4] = 32'h10;

        vecs[0] = '{32'h0000_0100, 0, 32'hE3A0_0001, 1'b0, 2, 1'b1};
        vecs[1] = '{32'h0000_0102, 0, 32'h0000_0000, 1'b1, 1, 1'b0};
        vecs[2] = '{32'h0000_0104, 2, 32'hE3A0_0005, 1'b0, 4, 1'b1};
        vecs[3] = '{32'h0000_0103, 0, 32'h0000_0000, 1'b1, 1, 1'b0};
        vecs[4] = '{32'hFFFF_FFFC, 1, 32'h1C5F_FEFD, 1'b0, 3, 1'b1};

        #2;
        check1("rst_mem_rd", mem_rd, 1'b0);
        check32("rst_mem_addr", mem_addr, '0);
        check1("rst_instr_valid", instr_valid, 1'b0);
        check32("rst_instr", instr, '0);
        check32("rst_instr_addr", instr_addr, '0);
        check1("rst_instr_fault", instr_fault, 1'b0);
        check1("rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            fetch_one(vecs[i].addr, vecs[i].delay, vecs[i].instr, vecs[i].fault,
                      vecs[i].lat, vecs[i].mrd);

        // back-to-back with decode stalled until the FIFO fills
        ack_delay = 0;
        pops0 = n_pops;
        for (int i = 0; i < 4; i++) begin
            present(bb[i]);
            wait_accept(20, ok, sa);
        end
        present(bb[4]);
        anyready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (req_ready) anyready = 1'b1;
        end
        check1("full_req_ready", anyready, 1'b0);
        check1("full_instr_valid", instr_valid, 1'b1);
        check32("full_head_addr", instr_addr, 32'h0);
        check1("full_busy", busy, 1'b1);
        @(posedge clk); #1;
        instr_ready = 1'b1;
        wait_accept(20, ok, sa);
        @(posedge clk); #1;
        req_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (!instr_valid && !busy) ok = 1'b1;
        end
        if (!ok) fail_now("b2b_drain_timeout", instr_addr);
        check32("b2b_pop_count", 32'(n_pops - pops0), 32'd5);
        @(posedge clk); #1;
        instr_ready = 1'b0;

        // flush while a fetch is in flight
        ack_delay = 3;
        present(32'h200);
        wait_accept(20, ok, sa);
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check1("flush_req_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        req_valid = 1'b1;
        req_addr = 32'h300;
        @(negedge clk);
        check1("drain_mem_rd", mem_rd, 1'b1);
        check1("drain_busy", busy, 1'b1);
        check1("drain_req_ready", req_ready, 1'b0);
        wait_accept(20, ok, sa);
        check1("drain_ack_before_accept", sa, 1'b1);
        check1("drain_no_valid", instr_valid, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_valid(30, ok, lat, sa);
        check32("after_drain_addr", instr_addr, 32'h300);
        check32("after_drain_instr", instr, 32'hE3A0_0201);
        pop_one();

        // flush with three queued entries and a simultaneous pop
        ack_delay = 0;
        for (int i = 0; i < 3; i++) begin
            present(bb[i]);
            wait_accept(20, ok, sa);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("queued_valid", instr_valid, 1'b1);
        @(posedge clk); #1;
        flush = 1'b1;
        instr_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        check1("flushq_instr_valid", instr_valid, 1'b0);
        check1("flushq_busy", busy, 1'b0);
        check1("flushq_req_ready", req_ready, 1'b1);

        // stray ack while idle must be ignored
        @(posedge clk); #1;
        stray_ack = 1'b1;
        @(posedge clk); #1;
        stray_ack = 1'b0;
        @(negedge clk);
        check1("stray_ack_valid", instr_valid, 1'b0);
        check1("stray_ack_busy", busy, 1'b0);

        // asynchronous reset in the middle of a fetch
        ack_delay = 5;
        present(32'h40);
        wait_accept(20, ok, sa);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #3;
        check1("pre_rst_mem_rd", mem_rd, 1'b1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check1("arst_mem_rd", mem_rd, 1'b0);
        check32("arst_mem_addr", mem_addr, '0);
        check1("arst_instr_valid", instr_valid, 1'b0);
        check32("arst_instr", instr, '0);
        check32("arst_instr_addr", instr_addr, '0);
        check1("arst_instr_fault", instr_fault, 1'b0);
        check1("arst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fetch_one(32'h40, 0, 32'hE3A0_0141, 1'b0, 2, 1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
